// File: rtl/ram_responder_if.sv
// Client rq/ack bus between a requesting client and a memory responder.
// The master modport drives requests; the slave modport answers them.
interface ram_responder_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  rq;
  logic                  wr_ni;
  logic [DATA_WIDTH-1:0] dataW;
  logic                  ack;
  logic [DATA_WIDTH-1:0] dataR;

  modport master (
    output address, rq, wr_ni, dataW,
    input  ack, dataR
  );

  modport slave (
    input  address, rq, wr_ni, dataW,
    output ack, dataR
  );
endinterface

// File: rtl/ram_responder.sv
// Wait-state memory responder: answers its own address window after an LFSR-driven
// number of wait states, with a one-cycle ack pulse and a registered read port.
module ram_responder #(
  parameter int unsigned DATA_WIDTH           = 8,
  parameter int unsigned ADDR_WIDTH           = 4,
  parameter int unsigned ADDR_SPACE_BEGINNING = 0,
  parameter int unsigned ADDR_SPACE_END       = 3,
  parameter logic [4:0]  LFSR_SEED            = 5'b00011,
  parameter logic [4:0]  WAIT_MASK            = 5'b00011
) (
  input logic            clk,
  input logic            reset,
  ram_responder_if.slave bus
);
  localparam int unsigned Depth = ADDR_SPACE_END - ADDR_SPACE_BEGINNING + 1;
  localparam int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [ADDR_WIDTH-1:0] Base   = ADDR_WIDTH'(ADDR_SPACE_BEGINNING);
  localparam logic [ADDR_WIDTH-1:0] SpanM1 = ADDR_WIDTH'(ADDR_SPACE_END - ADDR_SPACE_BEGINNING);
  localparam logic [4:0] SeedN = (LFSR_SEED == 5'b00000) ? 5'b00001 : LFSR_SEED;

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [4:0]            lfsr_q, lfsr_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] data_r_q, data_r_d;

  logic [DATA_WIDTH-1:0] mem [Depth];

  logic [ADDR_WIDTH-1:0] addr_off;
  logic                  in_range;
  logic [IdxW-1:0]       rd_idx;
  logic                  rd_load;

  // Offset wraps for addresses below the window, so one compare covers both bounds.
  assign addr_off = bus.address - Base;
  assign in_range = (addr_off <= SpanM1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    rd_load  = 1'b0;
    rd_idx   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (bus.rq && in_range) begin
          cnt_d   = lfsr_q & WAIT_MASK;
          lfsr_d  = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
          idx_d   = addr_off[IdxW-1:0];
          wr_d    = bus.wr_ni;
          wdata_d = bus.dataW;
          if ((lfsr_q & WAIT_MASK) == 5'd0) begin
            state_d = StAck;
            rd_load = !bus.wr_ni;
            rd_idx  = addr_off[IdxW-1:0];
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!bus.rq) begin
          state_d = StIdle;
          cnt_d   = 5'd0;
        end else if (cnt_q == 5'd1) begin
          state_d = StAck;
          cnt_d   = 5'd0;
          rd_load = !wr_q;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    data_r_d = rd_load ? mem[rd_idx] : data_r_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      lfsr_q   <= SeedN;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      data_r_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      data_r_q <= data_r_d;
    end
  end

  // Memory is not reset; a reset landing on the ACK edge drops the pending write.
  always_ff @(posedge clk) begin
    if (reset && (state_q == StAck) && wr_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.ack   = (state_q == StAck);
  assign bus.dataR = data_r_q;
endmodule

// File: tb/tb_ram_responder.sv
// Randomized scoreboard bench for ram_responder: a driver predicts ack cycle and
// read data from a behavioural model; a negedge monitor pops and compares on ack.
module tb_ram_responder;
  localparam int Beg  = 0;
  localparam int End  = 3;
  localparam int Seed = 3;
  localparam int Mask = 3;

  typedef struct {
    bit         rd;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t       sb[$];
  int         ref_lfsr = Seed;
  logic [7:0] ref_mem [4];
  logic [7:0] ref_last = 8'h00;
  bit         prev_ack = 1'b0;

  ram_responder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  ram_responder #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .ADDR_SPACE_BEGINNING(Beg), .ADDR_SPACE_END(End),
    .LFSR_SEED(5'b00011), .WAIT_MASK(5'b00011)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lfsr_next(input int l);
    return ((l << 1) & 31) | (((l >> 4) ^ (l >> 2)) & 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.ack) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_cycle", cyc, e.cyc);
          if (e.rd) check("rd_data", int'(bus.dataR), int'(e.data));
        end
        if (prev_ack) check("ack_double", 1, 0);
      end
      prev_ack = bus.ack;
    end else begin
      prev_ack = 1'b0;
    end
  end

  // Called #1 after a posedge; returns #1 after the edge that samples ack (or after hold).
  task automatic req(input int a, input bit w, input logic [7:0] d, input bit keep);
    int   t;
    int   wcnt;
    bit   got;
    exp_t e;
    bus.address = 4'(a);
    bus.wr_ni   = w;
    bus.dataW   = d;
    bus.rq      = 1'b1;
    t = cyc + 1;
    if (a >= Beg && a <= End) begin
      wcnt = ref_lfsr & Mask;
      ref_lfsr = lfsr_next(ref_lfsr);
      e.rd   = !w;
      e.data = w ? 8'h00 : ref_mem[a - Beg];
      e.cyc  = t + wcnt;
      sb.push_back(e);
      if (w) ref_mem[a - Beg] = d;
      else ref_last = ref_mem[a - Beg];
      got = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
        @(posedge clk);
        #1;
        if (bus.ack) got = 1'b1;
      end
      if (!got) begin
        check("ack_timeout", 0, 1);
        sb.delete();
      end
      @(posedge clk);
      #1;
    end else begin
      repeat (6) @(posedge clk);
      #1;
    end
    if (!keep) bus.rq = 1'b0;
  endtask

  task automatic ensure_long_wait(input int a);
    while ((ref_lfsr & Mask) < 2) req(a, 1'b0, 8'h00, 1'b0);
  endtask

  // Start a write and either drop rq or pull reset one cycle into WAIT.
  task automatic cut_write(input int a, input logic [7:0] d, input bit use_reset);
    ensure_long_wait(a);
    bus.address = 4'(a);
    bus.wr_ni   = 1'b1;
    bus.dataW   = d;
    bus.rq      = 1'b1;
    ref_lfsr = lfsr_next(ref_lfsr);
    @(posedge clk);
    #1;
    if (use_reset) begin
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("rst_ack", int'(bus.ack), 0);
      check("rst_dataR", int'(bus.dataR), 0);
      reset = 1'b1;
      bus.rq = 1'b0;
      ref_lfsr = Seed;
      ref_last = 8'h00;
    end else begin
      @(posedge clk);
      #1;
      bus.rq = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.rq = 1'b0;
    bus.address = '0;
    bus.wr_ni = 1'b0;
    bus.dataW = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack", int'(bus.ack), 0);
    check("reset_dataR", int'(bus.dataR), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    req(2, 1'b1, 8'hA5, 1'b0);
    req(2, 1'b0, 8'h00, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("dataR_hold", int'(bus.dataR), 8'hA5);

    // Out-of-range request held for 20 cycles must never be answered.
    bus.address = 4'd7;
    bus.wr_ni = 1'b0;
    bus.rq = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    bus.rq = 1'b0;
    req(0, 1'b1, 8'h10, 1'b0);

    req(1, 1'b1, 8'h11, 1'b0);
    cut_write(1, 8'h3C, 1'b0);
    req(1, 1'b0, 8'h00, 1'b0);
    check("abort_kept", int'(bus.dataR), 8'h11);

    cut_write(2, 8'h77, 1'b1);
    req(2, 1'b0, 8'h00, 1'b0);
    check("rst_mem_kept", int'(bus.dataR), 8'hA5);

    for (int i = 0; i < 4; i++) req(i, 1'b1, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 4; i++) req(i, 1'b0, 8'h00, (i < 3));

    for (int n = 0; n < 60; n++) begin
      req(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 8'($urandom),
          ($urandom_range(0, 2) == 0));
    end
    bus.rq = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("final_dataR", int'(bus.dataR), int'(ref_last));
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
